// File: rtl/rs_wakeup_req.sv
// Reservation-station wakeup/request block.
// Tracks operand readiness per entry and raises issue requests.
module rs_wakeup_req #(
  parameter int WIDTH = 16,
  parameter int REQS  = 3,
  parameter int TAGW  = 6,
  parameter int CDBW  = 3,
  parameter int IDXW  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_valid,
  input  logic [IDXW-1:0]        alloc_idx,
  input  logic [TAGW-1:0]        alloc_tag1,
  input  logic [TAGW-1:0]        alloc_tag2,
  input  logic                   alloc_rdy1,
  input  logic                   alloc_rdy2,
  input  logic [CDBW-1:0]        cdb_valid,
  input  logic [CDBW*TAGW-1:0]   cdb_tag,
  input  logic [WIDTH*REQS-1:0]  gnt_bus,
  input  logic                   squash,
  output logic [WIDTH-1:0]       req,
  output logic [WIDTH-1:0]       entry_valid,
  output logic [IDXW:0]          free_cnt,
  output logic                   full,
  output logic                   empty,
  output logic                   alloc_err
);

  logic [WIDTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] rdy1_q, rdy1_d;
  logic [WIDTH-1:0] rdy2_q, rdy2_d;
  logic [TAGW-1:0]  tag1_q [WIDTH];
  logic [TAGW-1:0]  tag1_d [WIDTH];
  logic [TAGW-1:0]  tag2_q [WIDTH];
  logic [TAGW-1:0]  tag2_d [WIDTH];
  logic             alloc_err_q, alloc_err_d;

  logic [WIDTH-1:0] gnt_or, gnt_eff;
  logic [WIDTH-1:0] wake1, wake2;
  logic             byp1, byp2;
  logic             alloc_ok, alloc_rej;
  logic [IDXW:0]    free_c;

  assign req         = valid_q & rdy1_q & rdy2_q;
  assign entry_valid = valid_q;
  assign alloc_err   = alloc_err_q;
  assign free_cnt    = free_c;
  assign full        = (free_c == '0);
  assign empty       = (free_c == (IDXW+1)'(WIDTH));

  // Merge selector grant slices; only requesting entries may issue
  always_comb begin
    gnt_or = '0;
    for (int j = 0; j < REQS; j++) begin
      gnt_or = gnt_or | gnt_bus[j*WIDTH +: WIDTH];
    end
    gnt_eff = gnt_or & req;
  end

  // Tag compare of every CDB lane against stored and incoming tags
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    byp1  = 1'b0;
    byp2  = 1'b0;
    for (int k = 0; k < CDBW; k++) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (cdb_tag[k*TAGW +: TAGW] == tag1_q[i]) wake1[i] = 1'b1;
          if (cdb_tag[k*TAGW +: TAGW] == tag2_q[i]) wake2[i] = 1'b1;
        end
        if (cdb_tag[k*TAGW +: TAGW] == alloc_tag1) byp1 = 1'b1;
        if (cdb_tag[k*TAGW +: TAGW] == alloc_tag2) byp2 = 1'b1;
      end
    end
  end

  // An issuing entry may be reused in the same cycle
  assign alloc_ok  = alloc_valid &
                     (~valid_q[alloc_idx] | gnt_eff[alloc_idx]);
  assign alloc_rej = alloc_valid & valid_q[alloc_idx] &
                     ~gnt_eff[alloc_idx] & ~squash;

  // Next entry state: issue, wakeup, allocate, then squash wins
  always_comb begin
    valid_d     = valid_q & ~gnt_eff;
    rdy1_d      = rdy1_q | (valid_q & wake1);
    rdy2_d      = rdy2_q | (valid_q & wake2);
    tag1_d      = tag1_q;
    tag2_d      = tag2_q;
    alloc_err_d = alloc_rej;
    if (alloc_ok) begin
      valid_d[alloc_idx] = 1'b1;
      rdy1_d[alloc_idx]  = alloc_rdy1 | byp1;
      rdy2_d[alloc_idx]  = alloc_rdy2 | byp2;
      tag1_d[alloc_idx]  = alloc_tag1;
      tag2_d[alloc_idx]  = alloc_tag2;
    end
    if (squash) begin
      valid_d = '0;
    end
  end

  // Count of unoccupied entries
  always_comb begin
    free_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      free_c = free_c + (IDXW+1)'(~valid_q[i]);
    end
  end

  // State registers; tags need no reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q     <= '0;
      rdy1_q      <= '0;
      rdy2_q      <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rdy1_q      <= rdy1_d;
      rdy2_q      <= rdy2_d;
      alloc_err_q <= alloc_err_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

endmodule

// File: tb/tb_rs_wakeup_req.sv
// Bench for rs_wakeup_req: directed vector table plus
// randomized traffic against a behavioural entry model.
module tb_rs_wakeup_req;

  localparam int W = 8, R = 2, TW = 6, C = 2, IW = 3;

  logic          clock = 0;
  logic          reset = 0;
  logic          alloc_valid = 0;
  logic [IW-1:0] alloc_idx = 0;
  logic [TW-1:0] alloc_tag1 = 0, alloc_tag2 = 0;
  logic          alloc_rdy1 = 0, alloc_rdy2 = 0;
  logic [C-1:0]  cdb_valid = 0;
  logic [C*TW-1:0] cdb_tag = 0;
  logic [W*R-1:0]  gnt_bus = 0;
  logic          squash = 0;
  logic [W-1:0]  req, entry_valid;
  logic [IW:0]   free_cnt;
  logic          full, empty, alloc_err;

  rs_wakeup_req #(.WIDTH(W), .REQS(R), .TAGW(TW),
                  .CDBW(C), .IDXW(IW)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .gnt_bus(gnt_bus), .squash(squash),
    .req(req), .entry_valid(entry_valid),
    .free_cnt(free_cnt), .full(full), .empty(empty),
    .alloc_err(alloc_err));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: one record per entry
  typedef struct {
    bit v; bit r1; bit r2;
    bit [TW-1:0] t1; bit [TW-1:0] t2;
  } ent_t;
  ent_t m [W];
  bit   m_err = 0;

  function automatic bit on_cdb(bit [TW-1:0] t);
    for (int k = 0; k < C; k++)
      if (cdb_valid[k] && cdb_tag[k*TW +: TW] == t) return 1;
    return 0;
  endfunction

  function automatic bit m_req(int i);
    return m[i].v && m[i].r1 && m[i].r2;
  endfunction

  function automatic bit granted(int i);
    bit g = 0;
    for (int j = 0; j < R; j++) g |= gnt_bus[j*W + i];
    return g && m_req(i);
  endfunction

  task automatic model_step();
    ent_t n [W];
    bit   e = 0;
    if (!reset) begin
      foreach (m[i]) begin m[i].v = 0; m[i].r1 = 0; m[i].r2 = 0; end
      m_err = 0;
      return;
    end
    foreach (m[i]) begin
      n[i] = m[i];
      if (m[i].v) begin
        if (on_cdb(m[i].t1)) n[i].r1 = 1;
        if (on_cdb(m[i].t2)) n[i].r2 = 1;
      end
      if (granted(i)) n[i].v = 0;
    end
    if (alloc_valid) begin
      int a = int'(alloc_idx);
      if (!m[a].v || granted(a)) begin
        n[a].v  = 1;
        n[a].t1 = alloc_tag1;
        n[a].t2 = alloc_tag2;
        n[a].r1 = alloc_rdy1 || on_cdb(alloc_tag1);
        n[a].r2 = alloc_rdy2 || on_cdb(alloc_tag2);
      end else if (!squash) begin
        e = 1;
      end
    end
    if (squash) foreach (n[i]) n[i].v = 0;
    m = n;
    m_err = e;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  typedef struct {
    bit rstn; bit av; bit [2:0] idx;
    bit [5:0] t1; bit [5:0] t2; bit r1; bit r2;
    bit [1:0] cv; bit [11:0] ct; bit [15:0] gnt; bit sq;
    bit [7:0] ereq; bit [7:0] eev; bit eerr;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit rstn, bit av, bit [2:0] idx,
      bit [5:0] t1, bit [5:0] t2, bit r1, bit r2, bit [1:0] cv,
      bit [11:0] ct, bit [15:0] gnt, bit sq,
      bit [7:0] ereq, bit [7:0] eev, bit eerr);
    vec_t v;
    v.rstn = rstn; v.av = av; v.idx = idx; v.t1 = t1; v.t2 = t2;
    v.r1 = r1; v.r2 = r2; v.cv = cv; v.ct = ct; v.gnt = gnt;
    v.sq = sq; v.ereq = ereq; v.eev = eev; v.eerr = eerr;
    return v;
  endfunction

  task automatic check_outs(string p, bit [7:0] er, bit [7:0] ev,
                            bit ee);
    int fc = W - $countones(ev);
    chk({p, ".req"}, 32'(req), 32'(er));
    chk({p, ".valid"}, 32'(entry_valid), 32'(ev));
    chk({p, ".free"}, 32'(free_cnt), 32'(fc));
    chk({p, ".full"}, 32'(full), 32'(fc == 0));
    chk({p, ".empty"}, 32'(empty), 32'(fc == W));
    chk({p, ".err"}, 32'(alloc_err), 32'(ee));
  endtask

  initial begin
    // reset with traffic and selector all-ones
    vq.push_back(mk(0,1,3,5,5,1,1,2'b11,{6'd5,6'd5},16'hffff,0,
                    8'h00,8'h00,0));
    vq.push_back(mk(1,1,3,5,9,0,0,0,0,0,0, 8'h00,8'h08,0));
    vq.push_back(mk(1,0,0,0,0,0,0,2'b11,{6'd5,6'd5},0,0,
                    8'h00,8'h08,0));
    vq.push_back(mk(1,0,0,0,0,0,0,2'b10,{6'd9,6'd0},0,0,
                    8'h08,8'h08,0));
    vq.push_back(mk(1,1,2,7,0,0,1,2'b01,{6'd0,6'd7},0,0,
                    8'h0C,8'h0C,0));
    vq.push_back(mk(1,1,1,1,1,1,1,0,0,0,0, 8'h0E,8'h0E,0));
    vq.push_back(mk(1,1,6,2,2,1,1,0,0,0,0, 8'h4E,8'h4E,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,16'h4002,0, 8'h0C,8'h0C,0));
    vq.push_back(mk(1,1,4,20,21,0,0,0,0,0,0, 8'h0C,8'h1C,0));
    vq.push_back(mk(1,1,4,30,31,1,1,0,0,0,0, 8'h0C,8'h1C,1));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 8'h0C,8'h1C,0));
    vq.push_back(mk(1,0,0,0,0,0,0,2'b11,{6'd21,6'd20},0,0,
                    8'h1C,8'h1C,0));
    vq.push_back(mk(1,1,4,30,31,0,0,0,0,16'h0010,0, 8'h0C,8'h1C,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,16'h0010,0, 8'h0C,8'h1C,0));
    vq.push_back(mk(1,1,0,40,41,0,0,0,0,0,0, 8'h0C,8'h1D,0));
    vq.push_back(mk(1,1,5,40,41,0,0,0,0,0,0, 8'h0C,8'h3D,0));
    vq.push_back(mk(1,1,7,40,41,0,0,0,0,0,0, 8'h0C,8'hBD,0));
    vq.push_back(mk(1,1,1,40,41,0,0,0,0,0,0, 8'h0C,8'hBF,0));
    vq.push_back(mk(1,1,6,40,41,0,0,0,0,0,0, 8'h0C,8'hFF,0));
    vq.push_back(mk(1,1,3,40,41,0,0,0,0,0,0, 8'h0C,8'hFF,1));
    vq.push_back(mk(1,1,0,1,1,1,1,0,0,0,1, 8'h00,8'h00,0));
    vq.push_back(mk(1,1,5,3,4,1,0,0,0,0,0, 8'h00,8'h20,0));
    vq.push_back(mk(0,1,2,4,4,0,0,2'b11,{6'd4,6'd4},16'hffff,0,
                    8'h00,8'h00,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 8'h00,8'h00,0));
    vq.push_back(mk(1,0,0,0,0,0,0,2'b01,{6'd0,6'd50},0,0,
                    8'h00,8'h00,0));
    vq.push_back(mk(1,1,0,50,50,0,0,0,0,0,0, 8'h00,8'h01,0));

    #2;
    foreach (vq[n]) begin
      reset = vq[n].rstn; alloc_valid = vq[n].av;
      alloc_idx = vq[n].idx; alloc_tag1 = vq[n].t1;
      alloc_tag2 = vq[n].t2; alloc_rdy1 = vq[n].r1;
      alloc_rdy2 = vq[n].r2; cdb_valid = vq[n].cv;
      cdb_tag = vq[n].ct; gnt_bus = vq[n].gnt; squash = vq[n].sq;
      cycle();
      check_outs($sformatf("vec%0d", n), vq[n].ereq, vq[n].eev,
                 vq[n].eerr);
    end

    for (int c = 0; c < 3000; c++) begin
      bit [7:0] er, ev;
      reset       = ($urandom_range(0, 99) != 0);
      alloc_valid = ($urandom_range(0, 1) == 1);
      alloc_idx   = IW'($urandom_range(0, W-1));
      alloc_tag1  = TW'($urandom_range(0, 7));
      alloc_tag2  = TW'($urandom_range(0, 7));
      alloc_rdy1  = ($urandom_range(0, 3) == 0);
      alloc_rdy2  = ($urandom_range(0, 3) == 0);
      cdb_valid   = C'($urandom);
      cdb_tag     = {TW'($urandom_range(0, 7)),
                     TW'($urandom_range(0, 7))};
      gnt_bus     = ($urandom_range(0, 9) == 0) ? '1 :
                    (16'($urandom) & 16'($urandom));
      squash      = ($urandom_range(0, 39) == 0);
      cycle();
      er = 0; ev = 0;
      foreach (m[i]) begin
        ev[i] = m[i].v;
        er[i] = m_req(i);
      end
      check_outs($sformatf("rnd%0d", c), er, ev, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
